keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad by driving one row low at a time and sampling the four column inputs. Debounces whole-matrix snapshots and emits one press event per debounced key-down as a 4-bit key code. Events use a hold-until-acknowledged handshake. It is the input-side counterpart to the multiplexed seven-segment display path, feeding digit entry into the same board-level datapath.

Parameters:
SETTLE_CYCLES, 1000, clk cycles each row is driven before its columns are sampled (>=2)
DEBOUNCE_SCANS, 4, consecutive identical full-matrix frames required to accept a change (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
col  input  4  column lines, active-low (pulled up off-chip), asynchronous to clk
key_ack  input  1  consumer accepts the pending event
row  output  4  row drive, active-low, exactly one bit low outside reset
key_valid  output  1  press event pending
key_code  output  4  pending key = 4*row_index + col_index
key_down  output  1  debounced: a single key currently held
overflow  output  1  sticky: a press event was dropped

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst is high: row=4'hF, key_valid=0, key_code=0, key_down=0, overflow=0.
- Reset also clears the synchronizer, row index, timer, snapshot, debounce state and any pending event.
- A mid-operation reset drops any pending event; no event is produced after release until a full debounce completes.
- col passes through a 2-FF synchronizer before any use.
- Row sequencer:
  - Index r runs 0..3 and wraps 3 to 0. row = ~(4'b1 << r).
  - The first cycle after reset drives r=0.
  - Timer counts 0..SETTLE_CYCLES-1. At terminal count: store ~col_sync into snap[4r+3:4r], reset the timer, advance r.
  - A frame completes on the sample of r=3. Frame period = 4*SETTLE_CYCLES cycles.
- Frame classification, evaluated on the frame-complete cycle:
  - Zero bits set in snap gives NONE.
  - Exactly one bit set gives KEY(code = bit index).
  - Two or more bits set gives NONE (ghosting or ambiguity is never reported).
- Debounce, per frame:
  - If the candidate equals the previous candidate, the stable count increments, saturating at DEBOUNCE_SCANS. Otherwise the stable count becomes 1.
  - When the stable count reaches DEBOUNCE_SCANS and the candidate differs from the held state, the held state is updated.
  - key_down = (held != NONE).
- Press event: raised when held changes to a KEY, including KEY-to-different-KEY with no NONE in between. Release raises no event.
- Event timing: key_valid rises the cycle after the frame-complete cycle, i.e. registered with key_code.
- Handshake:
  - key_valid and key_code stay stable until a cycle with key_ack=1; key_valid then falls on the next edge.
  - key_ack while key_valid=0 is ignored.
  - New event while key_valid=1 and key_ack=0: the new event is dropped, the old code is kept, overflow is set.
  - New event in the same cycle as key_ack: the new code loads, key_valid stays 1, overflow is unchanged.
  - overflow clears only on reset.
- Holding a key produces exactly one event, however long it is held.

Optional Feature:
Macro KEYPAD_REPEAT_EN.
- Defined: while held stays the same KEY, a repeat event with the same code is raised after 250 further frames, then every 50 frames thereafter. Counts reset on any held change. Repeat events follow the same handshake and overflow rules.
- Undefined: no repeat logic is built; behaviour is exactly one event per press.

Test Plan:
(Bench uses SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, so frame = 16 cycles.)
1. Reset release, no keys -> row sequence E,D,B,7 each held 4 cycles, repeating; key_valid, key_down and overflow stay 0.
2. Press r=2,c=1 for 3 frames -> key_valid=1 and key_code=9 the cycle after the 2nd frame completes; key_down=1; ack -> key_valid=0; no further event while held; release -> key_down=0 after 2 NONE frames.
3. Press lasting a single frame (bounce), then release -> no event, key_down stays 0.
4. Keys 0 and 5 pressed together for 4 frames -> no event, key_down=0.
5. Press 3 without ack, release, then press 12 -> key_code stays 3, overflow=1. Ack in the same cycle as the second event -> key_code=12, key_valid stays 1.
6. Assert rst mid-frame with key_valid=1 -> next cycle all outputs at reset values and row=4'hF; after release, scanning restarts at row=4'hE.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with whole-frame debounce and a hold-until-ack event.
// Define KEYPAD_REPEAT_EN to add auto-repeat events while a key stays held.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  input  logic       key_ack,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down,
  output logic       overflow
);

  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(DEBOUNCE_SCANS);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t        state;
  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [1:0]    ridx;
  logic [TW-1:0] timer;
  logic [15:0]   snap;
  logic [15:0]   snap_next;
  // Candidates and held state are {is_key, code}; all zero means NONE.
  logic [4:0]    cand;
  logic [4:0]    prev_cand;
  logic [4:0]    held;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] stable_inc;
  logic [4:0]    ones;
  logic [3:0]    hit_idx;
  logic          sample;
  logic          frame_done;
  logic          accept;
  logic          press_evt;
  logic          rep_evt;
  logic          new_evt;
  logic [3:0]    evt_code;

  assign sample     = (state == S_SCAN) && (timer == TIMER_LAST);
  assign frame_done = sample && (ridx == 2'd3);

  // Classify the frame including the row being sampled this cycle.
  always_comb begin
    snap_next = snap;
    snap_next[{ridx, 2'b00} +: 4] = ~col_sync;
    ones    = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_next[i]) begin
        ones    = ones + 5'd1;
        hit_idx = 4'(i);
      end
    end
    cand = (ones == 5'd1) ? {1'b1, hit_idx} : 5'd0;
  end

  always_comb begin
    if (cand != prev_cand)
      stable_inc = CW'(1);
    else if (stable_cnt == STABLE_MAX)
      stable_inc = stable_cnt;
    else
      stable_inc = stable_cnt + CW'(1);
  end

  assign accept    = frame_done && (stable_inc == STABLE_MAX) && (cand != held);
  assign press_evt = accept && cand[4];
  assign new_evt   = press_evt || rep_evt;
  assign evt_code  = accept ? cand[3:0] : held[3:0];
  assign key_down  = held[4];

`ifdef KEYPAD_REPEAT_EN
  logic [7:0] rep_cnt;
  logic       rep_first;

  // First repeat after 250 unchanged frames, then every 50.
  assign rep_evt = frame_done && !accept && held[4] &&
                   ((rep_cnt + 8'd1) == (rep_first ? 8'd250 : 8'd50));

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (frame_done) begin
      if (accept) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (held[4]) begin
        if (rep_evt) begin
          rep_cnt   <= '0;
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + 8'd1;
        end
      end
    end
  end
`else
  assign rep_evt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      col_meta   <= 4'hF;
      col_sync   <= 4'hF;
      ridx       <= 2'd0;
      timer      <= '0;
      row        <= 4'hF;
      snap       <= '0;
      prev_cand  <= '0;
      stable_cnt <= '0;
      held       <= '0;
      key_valid  <= 1'b0;
      key_code   <= 4'd0;
      overflow   <= 1'b0;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;

      case (state)
        S_IDLE: begin
          state <= S_SCAN;
          ridx  <= 2'd0;
          timer <= '0;
          row   <= 4'hE;
        end
        S_SCAN: begin
          if (sample) begin
            timer <= '0;
            snap  <= snap_next;
            ridx  <= ridx + 2'd1;
            row   <= ~(4'b0001 << (ridx + 2'd1));
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      if (frame_done) begin
        prev_cand  <= cand;
        stable_cnt <= stable_inc;
        if (accept)
          held <= cand;
      end

      // A pending unacknowledged event wins; a colliding new one is only flagged.
      if (new_evt) begin
        if (!key_valid || key_ack) begin
          key_valid <= 1'b1;
          key_code  <= evt_code;
        end else begin
          overflow <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios with a scoreboard of expected press events.
// Run with SETTLE_CYCLES=4 and DEBOUNCE_SCANS=2, so one frame is 16 cycles.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  col;
  logic        key_ack;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic        overflow;

  logic [15:0] pressed;
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic        took_ack;
  logic        prev_valid;

  typedef struct {
    int code;
    int at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  keypad_scanner #(
    .SETTLE_CYCLES (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .key_ack  (key_ack),
    .row      (row),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_down (key_down),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int rr = 0; rr < 4; rr++) begin
      if (!row[rr]) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[4*rr + c])
            col[c] = 1'b0;
        end
      end
    end
  end

  initial begin
    cyc        = 0;
    n_checks   = 0;
    n_fail     = 0;
    took_ack   = 1'b0;
    prev_valid = 1'b0;
  end

  always @(posedge clk) begin
    took_ack <= key_valid && key_ack;
    if (rst)
      cyc <= 0;
    else
      cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic expectEvent(input int code, input int at);
    exp_t e;
    e.code = code;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic runTo(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: a new event is presented when valid rises or reloads in an ack cycle.
  always @(negedge clk) begin
    if (key_valid && (!prev_valid || took_ack)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_event at cycle %0d: got code %0d, expected no event", cyc, key_code);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("event_code", int'(key_code), mon_e.code);
        checkOutput("event_cycle", cyc, mon_e.at);
      end
    end
    prev_valid = key_valid;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst     = 1'b1;
    key_ack = 1'b0;
    applyStimulus(16'h0000);

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_row", int'(row), 4'hF);
    checkOutput("rst_valid", int'(key_valid), 0);
    checkOutput("rst_code", int'(key_code), 0);
    checkOutput("rst_down", int'(key_down), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    rst = 1'b0;

    // 1: idle scanning, rows E,D,B,7 four cycles each
    for (int c = 1; c <= 32; c++) begin
      logic [3:0] er;
      runTo(c);
      er = ~(4'b0001 << (((c - 1) / 4) % 4));
      checkOutput("row_seq", int'(row), int'(er));
    end
    checkOutput("idle_valid", int'(key_valid), 0);
    checkOutput("idle_down", int'(key_down), 0);
    checkOutput("idle_overflow", int'(overflow), 0);

    // 2: key 9 for frames 3..5, event after frame 4 (cycle 65)
    applyStimulus(16'h0200);
    expectEvent(9, 65);
    runTo(64);
    checkOutput("k9_down_before", int'(key_down), 0);
    runTo(65);
    checkOutput("k9_down", int'(key_down), 1);
    runTo(66);
    key_ack = 1'b1;
    runTo(67);
    key_ack = 1'b0;
    checkOutput("k9_ack_clears", int'(key_valid), 0);
    runTo(81);
    checkOutput("k9_held_no_event", int'(key_valid), 0);
    checkOutput("k9_still_down", int'(key_down), 1);
    applyStimulus(16'h0000);
    runTo(112);
    checkOutput("k9_release_pending", int'(key_down), 1);
    runTo(113);
    checkOutput("k9_released", int'(key_down), 0);

    // 3: single-frame bounce on key 6
    applyStimulus(16'h0040);
    runTo(129);
    checkOutput("bounce_down", int'(key_down), 0);
    applyStimulus(16'h0000);
    runTo(145);
    checkOutput("bounce_down2", int'(key_down), 0);
    checkOutput("bounce_valid", int'(key_valid), 0);

    // 4: keys 0 and 5 together for four frames
    applyStimulus(16'h0021);
    runTo(209);
    checkOutput("multi_down", int'(key_down), 0);
    checkOutput("multi_valid", int'(key_valid), 0);
    applyStimulus(16'h0000);

    // 5a: key 3 left unacked, then key 12 is dropped
    runTo(225);
    applyStimulus(16'h0008);
    expectEvent(3, 257);
    runTo(257);
    applyStimulus(16'h0000);
    runTo(289);
    applyStimulus(16'h1000);
    runTo(320);
    checkOutput("ovf_before", int'(overflow), 0);
    runTo(321);
    checkOutput("ovf_set", int'(overflow), 1);
    checkOutput("ovf_code_kept", int'(key_code), 3);
    checkOutput("ovf_valid_kept", int'(key_valid), 1);
    applyStimulus(16'h0000);

    // 5b: key 12 again, acked in the same cycle the event arrives
    runTo(353);
    applyStimulus(16'h1000);
    expectEvent(12, 385);
    runTo(384);
    checkOutput("sameack_old_code", int'(key_code), 3);
    key_ack = 1'b1;
    runTo(385);
    key_ack = 1'b0;
    checkOutput("sameack_valid", int'(key_valid), 1);
    checkOutput("sameack_code", int'(key_code), 12);
    checkOutput("sameack_overflow", int'(overflow), 1);

    // 6: reset mid-frame with an event pending, key 12 still held
    runTo(390);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_row", int'(row), 4'hF);
    checkOutput("midrst_valid", int'(key_valid), 0);
    checkOutput("midrst_code", int'(key_code), 0);
    checkOutput("midrst_down", int'(key_down), 0);
    checkOutput("midrst_overflow", int'(overflow), 0);
    rst = 1'b0;
    expectEvent(12, 33);
    runTo(1);
    checkOutput("restart_row", int'(row), 4'hE);
    runTo(32);
    checkOutput("restart_no_early_valid", int'(key_valid), 0);
    checkOutput("restart_no_early_down", int'(key_down), 0);
    runTo(33);
    checkOutput("restart_down", int'(key_down), 1);
    runTo(34);
    key_ack = 1'b1;
    runTo(35);
    key_ack = 1'b0;
    checkOutput("restart_ack", int'(key_valid), 0);
    runTo(48);
    checkOutput("pending_events", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
